// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one combinational 64x8 glyph ROM between two
// requesters: latch address, capture row, pulse per-port ack.
module font_rom_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [1:0] char0,
  input  logic [3:0] row0,
  input  logic       req1,
  input  logic [1:0] char1,
  input  logic [3:0] row1,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] data0,
  output logic [7:0] data1,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ACK
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       grant_id;
  logic       grant_nx;
  logic       last;
  logic       last_nx;
  logic       win;
  logic [5:0] addr_nx;
  logic [7:0] data0_nx;
  logic [7:0] data1_nx;

  // On a tie the port that did not win last time is served.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0 & req1:  win = ~last;
      ~req0 & req1: win = 1'b1;
      default:      win = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_id;
    last_nx  = last;
    addr_nx  = rom_addr;
    data0_nx = data0;
    data1_nx = data1;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nx = FETCH;
          grant_nx = win;
          last_nx  = win;
          addr_nx  = win ? {char1, row1}
                         : {char0, row0};
        end
      end
      FETCH: begin
        state_nx = ACK;
        if (grant_id) data1_nx = rom_data;
        else          data0_nx = rom_data;
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id <= 1'b0;
      last     <= 1'b1;
      rom_addr <= 6'd0;
      data0    <= 8'd0;
      data1    <= 8'd0;
    end else begin
      grant_id <= grant_nx;
      last     <= last_nx;
      rom_addr <= addr_nx;
      data0    <= data0_nx;
      data1    <= data1_nx;
    end
  end

  // Acks are pure decodes of registered state, never of req.
  assign ack0 = (state == ACK) & ~grant_id;
  assign ack1 = (state == ACK) &  grant_id;
  assign busy = (state != IDLE);

endmodule

// File: doc/font_rom_arbiter.md
# font_rom_arbiter

Two-port round-robin arbiter and sequencer that shares the single 64x8 glyph ROM (`fontROM`) between two display requesters, such as the label overlay and the value overlay of the clock/timer screen. Each requester asks for one glyph row (char code plus row index). The arbiter drives the ROM address from a register and captures the 8-bit row. It then returns the row on that requester's data register with a one-cycle ack. The ROM is combinational; this block owns all sequencing around it.

## Interface
Parameters:
- none; ROM geometry is fixed: 4 glyphs x 16 rows, rom_addr = {char[1:0], row[3:0]}

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request level; held high until ack0 is seen
- char0  in  2  port 0 glyph code (0 null, 1 'F', 2 'H', 3 unused → reads 0)
- row0  in  4  port 0 glyph row index 0..15
- req1, char1, row1  in  1/2/4  port 1, same meaning
- rom_addr  out  6  registered address to fontROM.addr
- rom_data  in  8  fontROM.data (combinational from rom_addr)
- ack0  out  1  one-cycle pulse: data0 updated this cycle
- ack1  out  1  one-cycle pulse: data1 updated this cycle
- data0  out  8  port 0 glyph row, held until next ack0
- data1  out  8  port 1 glyph row, held until next ack1
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM has three states: IDLE → FETCH → ACK → IDLE. There are no other transitions except reset.
- IDLE: if any req is high, select a winner and latch its {char,row} into rom_addr. Record grant_id and go to FETCH. If no req is high, stay in IDLE and hold rom_addr.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port that is not `last` wins.
  - `last` updates to grant_id on every grant.
  - `last` resets to 1, so port 0 wins the first tie.
- FETCH: rom_addr is stable and rom_data is valid. At the end of the cycle, capture rom_data into data[grant_id]. The other port's data register is untouched. Go to ACK.
- ACK: ack[grant_id]=1 for exactly this cycle, then go to IDLE.
- req is sampled only in IDLE. Changes to req, char or row during FETCH or ACK are ignored.
- Requester contract: drop req on the clock edge that ends the ack cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
- A losing requester keeps req high. It is served by the next grant, so its wait is bounded by 3 cycles.
- Reset, including mid-operation:
  - Immediately: state=IDLE, rom_addr=0, data0=data1=0, ack0=ack1=0, busy=0, last=1.
  - An in-flight transaction is dropped and no ack is issued.

## Timing
- Latency: req sampled high in IDLE at cycle N. rom_addr is valid at N+1, data and ack are valid at N+2, and the FSM is back in IDLE at N+3.
- Peak throughput: 1 glyph row per 3 cycles, shared by both ports.
- ack0 and ack1 are never high in the same cycle.
- ack outputs are registered and decoded from the state and grant_id registers, with no combinational path from req.
- busy=1 during FETCH and ACK.
- rom_addr and the data registers change only on clk edges or on reset assertion.

## Test plan
- Reset: assert reset mid-FETCH with port 0 granted.
  - → all outputs 0 immediately, busy=0, no ack0.
  - After release, port 0 request char1/row2 → data0=0xFE with ack0 at N+2.
- Single port:
  - Port 1 char2/row6 → rom_addr=0x26 at N+1, data1=0xFE and ack1 at N+2, data0 unchanged.
  - Then char2/row2 → data1=0xC6.
- Tie: req0 and req1 both high from IDLE after reset, port 0 char1/row3, port 1 char2/row3.
  - → ack0 with data0=0x66 at cycle 2.
  - → ack1 with data1=0xC6 at cycle 5.
- Fairness: both ports hold req and re-request continuously for 12 cycles → acks alternate 0,1,0,1 with a 3-cycle spacing.
- Boundaries:
  - char0/row0 → 0x00.
  - char3/row5 → 0x00.
  - char1/row15 (addr 0x1F) → 0x00.
  - Changing char0 during FETCH does not alter the data0 captured.
- Held req: requester keeps req0 high after ack0 → a second grant in the next IDLE, ack0 again 3 cycles later.
